load_store_unit: RTL and testbench

- Byte-serial load/store sequencer between the CPU memory stage and the byte-wide data memory (8-bit data, combinational read, synchronous write).
- Turns one byte, half or word request into 1, 2 or 4 consecutive byte accesses, little-endian.
- Returns the assembled, sign- or zero-extended load result with a one-cycle response pulse.
- Holds req_ready low while busy so the pipeline can stall on it.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_extend.sv | 20 ++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size code 2'b11 behaves as a word.
  function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: bytes_for_size = 3'd1;
      SZ_HALF: bytes_for_size = 3'd2;
      default: bytes_for_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response channel of the load/store unit.
interface lsu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled load word by access size.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
      SZ_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store sequencer: splits byte/half/word requests into
// little-endian byte accesses. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  lsu_if.slave                     cpu,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata
);

  state_t                   state_reg, state_next;
  logic [1:0]               cnt_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [1:0]               size_reg;
  logic                     we_reg;
  logic                     uns_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic [31:0]              asm_reg;
  logic                     err_reg;
  logic [31:0]              ext_data;
  logic                     accept;
  logic                     misaligned;
  logic                     last_byte;

  assign accept    = (state_reg == IDLE) && cpu.req_valid;
  assign last_byte = (cnt_reg == 2'(bytes_for_size(size_reg) - 3'd1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((cpu.req_size == SZ_HALF) && cpu.req_addr[0]) ||
                      ((bytes_for_size(cpu.req_size) == 3'd4) && (cpu.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      addr_reg  <= '0;
      size_reg  <= SZ_BYTE;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      wdata_reg <= '0;
      asm_reg   <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= cpu.req_addr;
            size_reg  <= cpu.req_size;
            we_reg    <= cpu.req_we;
            uns_reg   <= cpu.req_unsigned;
            wdata_reg <= cpu.req_wdata;
            cnt_reg   <= 2'd0;
            asm_reg   <= 32'd0;
            err_reg   <= misaligned;
          end
        end
        XFER: begin
          if (!we_reg)
            asm_reg[{cnt_reg, 3'b000} +: 8] <= mem_rdata;
          if (!last_byte)
            cnt_reg <= cnt_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = misaligned ? RESP : XFER;
      XFER:    if (last_byte) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_extend u_extend (
    .raw         (asm_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .ext         (ext_data)
  );

  always_comb begin
    cpu.req_ready  = 1'b0;
    cpu.resp_valid = 1'b0;
    cpu.resp_rdata = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = 8'd0;
    case (state_reg)
      IDLE: cpu.req_ready = 1'b1;
      XFER: begin
        // Address arithmetic wraps naturally at the top of the space.
        mem_addr  = addr_reg + ADDRESS_WIDTH'(cnt_reg);
        mem_we    = we_reg;
        mem_wdata = wdata_reg[{cnt_reg, 3'b000} +: 8];
      end
      RESP: begin
        cpu.resp_valid = 1'b1;
        if (!we_reg && !err_reg)
          cpu.resp_rdata = DATA_WIDTH'(ext_data);
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign cpu.resp_err = (state_reg == RESP) && err_reg;
`else
  assign cpu.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem [0:4095];
  int          n_checks;
  int          n_fail;

  lsu_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low 12 address bits index the model; the addresses used do not alias.
  assign mem_rdata = mem[mem_addr[11:0]];
  always @(posedge clk) begin
    if (mem_we === 1'b1)
      mem[mem_addr[11:0]] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input string name);
    int  n;
    bit  trap;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((size == 2'b01) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`endif
    @(negedge clk);
    check({name, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!trap) begin
      for (int i = 0; i < n; i++) begin
        check({name, " busy"}, 32'(bus.req_ready), 32'd0);
        check({name, " mem_we"}, 32'(mem_we), 32'(we));
        check({name, " mem_addr"}, mem_addr, addr + 32'(i));
        if (we)
          check({name, " mem_wdata"}, 32'(mem_wdata), 32'(wdata[8*i +: 8]));
        @(negedge clk);
      end
    end
    check({name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({name, " resp_rdata"}, bus.resp_rdata, trap ? 32'd0 : exp_rdata);
    check({name, " resp_err"}, 32'(bus.resp_err), 32'(trap));
    check({name, " resp mem_we"}, 32'(mem_we), 32'd0);
    @(negedge clk);
    check({name, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
    $display("txn %s we=%0d size=%0d addr=%h rdata=%h", name, we, size, addr, exp_rdata);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[12'h200 + i] = 8'hAA;
    mem[12'hFFE] = 8'h01;
    mem[12'hFFF] = 8'h02;
    mem[12'h000] = 8'h03;
    mem[12'h001] = 8'h04;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    // Word store aborted by reset after two bytes
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h200;
    bus.req_wdata = 32'h11223344; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort mem_addr", mem_addr, 32'h202);
    rst = 1'b1;
    #1;
    check("abort mem_we", 32'(mem_we), 32'd0);
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort no resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    check("abort byte0", 32'(mem[12'h200]), 32'h44);
    check("abort byte1", 32'(mem[12'h201]), 32'h33);
    check("abort byte2", 32'(mem[12'h202]), 32'hAA);
    check("abort byte3", 32'(mem[12'h203]), 32'hAA);
    $display("txn reset-abort SW addr=00000200");

    // Store then loads of every size
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, "SW");
    check("SW mem100", 32'(mem[12'h100]), 32'hEF);
    check("SW mem101", 32'(mem[12'h101]), 32'hBE);
    check("SW mem102", 32'(mem[12'h102]), 32'hAD);
    check("SW mem103", 32'(mem[12'h103]), 32'hDE);
    run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, "LW");
    run_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 32'hFFFFDEAD, "LH");
    run_txn(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 32'h0000DEAD, "LHU");
    run_txn(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, 32'hFFFFFFBE, "LB");
    run_txn(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 32'h000000BE, "LBU");
    run_txn(1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 32'hFFFFFFEF, "LB0");
    run_txn(1'b0, 2'b11, 1'b1, 32'h100, 32'd0, 32'hDEADBEEF, "LW11");

    // Back-to-back byte stores with req_valid held high
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_addr = 32'h300;
    bus.req_wdata = 32'h0000005A; bus.req_valid = 1'b1;
    check("b2b ready0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("b2b xfer1 ready", 32'(bus.req_ready), 32'd0);
    check("b2b xfer1 addr", mem_addr, 32'h300);
    check("b2b xfer1 data", 32'(mem_wdata), 32'h5A);
    bus.req_addr = 32'h301; bus.req_wdata = 32'h000000A5;
    @(negedge clk);
    check("b2b resp1 valid", 32'(bus.resp_valid), 32'd1);
    check("b2b resp1 ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("b2b idle ready", 32'(bus.req_ready), 32'd1);
    check("b2b idle mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b xfer2 ready", 32'(bus.req_ready), 32'd0);
    check("b2b xfer2 we", 32'(mem_we), 32'd1);
    check("b2b xfer2 addr", mem_addr, 32'h301);
    check("b2b xfer2 data", 32'(mem_wdata), 32'hA5);
    @(negedge clk);
    check("b2b resp2 valid", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    check("b2b mem300", 32'(mem[12'h300]), 32'h5A);
    check("b2b mem301", 32'(mem[12'h301]), 32'hA5);
    $display("txn back-to-back SB 300/301");

    // Address wrap across the top of the space
    run_txn(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0, 32'h04030201, "LWwrap");

    // Misaligned word store: trapped or performed byte-serially
    run_txn(1'b1, 2'b10, 1'b0, 32'h101, 32'h11223344, 32'd0, "SWmis");
`ifdef LSU_MISALIGN_TRAP_EN
    check("SWmis mem101", 32'(mem[12'h101]), 32'hBE);
    check("SWmis mem104", 32'(mem[12'h104]), 32'h00);
`else
    check("SWmis mem101", 32'(mem[12'h101]), 32'h44);
    check("SWmis mem104", 32'(mem[12'h104]), 32'h11);
`endif
    check("SWmis mem100", 32'(mem[12'h100]), 32'hEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
